vpm_hazard_ctrl: RTL

- Central hazard controller: the producer side of the per-stage stall/flush enables that VPM pipeline stages consume (hz_stall_n_*, hz_flush_n_*).
- Collects stall, flush and multicycle-op requests from each stage.
- Resolves these requests into per-stage active-low stall and flush enables, with correct bubble insertion and priority.
- Sits beside the pipeline; one instance per pipeline.

---
 rtl/vpm_hz_pkg.sv | 11 +
 rtl/vpm_hz_mcyc_timer.sv | 58 +++++
 rtl/vpm_hazard_ctrl.sv | 63 ++++++
 3 files changed

// File: rtl/vpm_hz_pkg.sv
// vpm_hz_pkg: shared types and helpers for the VPM hazard controller
package vpm_hz_pkg;
  typedef enum logic {HZ_IDLE, HZ_HOLD} hz_state_t;
  localparam int STAT_W = 32;
  function automatic int hsb(input logic [31:0] v);
    int r;
    r = -1;
    for (int i = 0; i < 32; i++) if (v[i]) r = i;
    return r;
  endfunction
endpackage

// File: rtl/vpm_hz_mcyc_timer.sv
// vpm_hz_mcyc_timer: IDLE/HOLD multicycle hold FSM with countdown
// Ports: i_clk/i_rst_n clock and async active-low reset; i_start/i_cycles/i_stage
// request a hold of i_cycles cycles on stage i_stage; i_abort ends a hold early;
// o_busy marks HOLD, o_stage is the latched held stage.
module vpm_hz_mcyc_timer
  import vpm_hz_pkg::*;
#(
  parameter int STAGES    = 5,
  parameter int CNT_WIDTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_start,
  input  logic [CNT_WIDTH-1:0]       i_cycles,
  input  logic [$clog2(STAGES)-1:0]  i_stage,
  input  logic                       i_abort,
  output logic                       o_busy,
  output logic [$clog2(STAGES)-1:0]  o_stage
);
  hz_state_t r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic [$clog2(STAGES)-1:0] r_stage, w_stage_nxt;
  logic w_go;
  // out-of-range stages and zero-length holds never leave IDLE
  assign w_go = i_start && i_cycles != '0 && 32'(i_stage) < STAGES;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state <= HZ_IDLE;
      r_cnt   <= '0;
      r_stage <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_stage <= w_stage_nxt;
    end
  // counter holds remaining cycles minus one, so HOLD lasts exactly i_cycles
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stage_nxt = r_stage;
    if (r_state == HZ_IDLE) begin
      if (w_go) begin
        w_state_nxt = HZ_HOLD;
        w_cnt_nxt   = i_cycles - CNT_WIDTH'(1);
        w_stage_nxt = i_stage;
      end
    end else if (i_abort || r_cnt == '0) begin
      w_state_nxt = HZ_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      w_cnt_nxt = r_cnt - CNT_WIDTH'(1);
    end
  end
  always_ff @(posedge i_clk)
    if (i_rst_n && i_start) assert (32'(i_stage) < STAGES);
  assign o_busy  = r_state == HZ_HOLD;
  assign o_stage = r_stage;
endmodule

// File: rtl/vpm_hazard_ctrl.sv
// vpm_hazard_ctrl: resolves per-stage stall/flush/multicycle requests into active-low stall and flush enables
// Ports: clk/rst_n clock and async active-low reset; stall_req (level) and flush_req (pulse)
// per stage; mc_start/mc_stage/mc_cycles multicycle hold request; hz_stall_n/hz_flush_n
// per-stage enables (0 = hold / load bubble); mc_busy hold in progress.
// Optional VPM_HZ_STATS_EN adds saturating stat_stall_cycles and stat_flushes counters.
module vpm_hazard_ctrl
  import vpm_hz_pkg::*;
#(
  parameter int STAGES    = 5,
  parameter int CNT_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [STAGES-1:0]          stall_req,
  input  logic [STAGES-1:0]          flush_req,
  input  logic                       mc_start,
  input  logic [$clog2(STAGES)-1:0]  mc_stage,
  input  logic [CNT_WIDTH-1:0]       mc_cycles,
  output logic [STAGES-1:0]          hz_stall_n,
  output logic [STAGES-1:0]          hz_flush_n,
`ifdef VPM_HZ_STATS_EN
  output logic [STAT_W-1:0]          stat_stall_cycles,
  output logic [STAT_W-1:0]          stat_flushes,
`endif
  output logic                       mc_busy
);
  logic r_init;
  logic w_abort;
  logic [$clog2(STAGES)-1:0] w_held;
  int w_s, w_f;
  vpm_hz_mcyc_timer #(.STAGES(STAGES), .CNT_WIDTH(CNT_WIDTH)) u_timer (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(mc_start), .i_cycles(mc_cycles),
    .i_stage(mc_stage), .i_abort(w_abort), .o_busy(mc_busy), .o_stage(w_held)
  );
  // keeps every stage flushed through reset and the first cycle after release
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_init <= 1'b1;
    else r_init <= 1'b0;
  // S = w_s, F = w_f (-1 when absent); stall effects only reach stages >= F
  always_comb begin
    w_f = hsb(32'(flush_req));
    w_s = hsb(32'(stall_req));
    if (mc_busy && int'(w_held) > w_s) w_s = int'(w_held);
    for (int j = 0; j < STAGES; j++) begin
      hz_stall_n[j] = r_init || !(j <= w_s && j >= w_f);
      hz_flush_n[j] = !r_init && !(j < w_f || (w_s >= 0 && j == w_s + 1));
    end
  end
  assign w_abort = mc_busy && w_f > int'(w_held);
`ifdef VPM_HZ_STATS_EN
  logic [STAT_W-1:0] r_stall_cnt, r_flush_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!(&hz_stall_n) && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + STAT_W'(1);
      if ((|flush_req) && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + STAT_W'(1);
    end
  assign stat_stall_cycles = r_stall_cnt;
  assign stat_flushes      = r_flush_cnt;
`endif
endmodule
